// File: rtl/fade_pkg.sv
// fade_pkg: shared fade state encoding and duty-width helper
package fade_pkg;
  typedef enum logic [2:0] {WAIT, INC, HOLD, DEC, OFF} fade_state_t;
  function automatic int duty_w(input int full_scale);
    return $clog2(full_scale + 1);
  endfunction
endpackage

// File: rtl/fade_channel.sv
// fade_channel: one brightness FSM with tick counter, duty register and PWM compare
module fade_channel import fade_pkg::*; #(
  parameter int STEPS = 200,
  parameter int HOLD_STEPS = 400,
  parameter int OFF_STEPS = 400,
  parameter int PWM_INTERVAL = 1200,
  parameter int START_DELAY = 0,
  localparam int DW = duty_w(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_tick,
  input  logic [DW-1:0] i_pwm_cnt,
  output logic [DW-1:0] o_duty,
  output fade_state_t   o_state,
  output logic          o_pwm,
  output logic          o_leave_off
);
  localparam logic [DW-1:0] FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP = DW'(PWM_INTERVAL / STEPS);
  fade_state_t r_state, w_state_n;
  logic [31:0] r_cnt, w_cnt_n, w_len;
  logic [DW-1:0] r_duty, w_duty_n, w_up, w_dn;
  logic r_pwm, w_done;
  assign w_len = r_state == WAIT ? 32'(START_DELAY) : r_state == HOLD ? 32'(HOLD_STEPS) :
                 r_state == OFF ? 32'(OFF_STEPS) : 32'(STEPS);
  assign w_done = r_cnt == w_len - 32'd1;
  // saturating steps written so neither direction can wrap the register
  assign w_up = (FULL - r_duty <= STEP) ? FULL : r_duty + STEP;
  assign w_dn = (r_duty <= STEP) ? '0 : r_duty - STEP;
  always_comb begin
    w_state_n = r_state;
    w_duty_n = r_duty;
    w_cnt_n = w_done ? 32'd0 : r_cnt + 32'd1;
    case (r_state)
      WAIT: begin
        w_state_n = w_done ? INC : WAIT;
        w_duty_n = '0;
      end
      INC: begin
        w_state_n = w_done ? HOLD : INC;
        w_duty_n = w_done ? FULL : w_up;
      end
      HOLD: begin
        w_state_n = w_done ? DEC : HOLD;
        w_duty_n = FULL;
      end
      DEC: begin
        w_state_n = w_done ? OFF : DEC;
        w_duty_n = w_done ? '0 : w_dn;
      end
      OFF: begin
        w_state_n = w_done ? INC : OFF;
        w_duty_n = '0;
      end
      default: begin
        w_state_n = OFF;
        w_duty_n = '0;
        w_cnt_n = 32'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (START_DELAY == 0) ? INC : WAIT;
      r_cnt <= '0;
      r_duty <= '0;
      r_pwm <= 1'b0;
    end else begin
      if (i_tick) begin
        r_state <= w_state_n;
        r_cnt <= w_cnt_n;
        r_duty <= w_duty_n;
      end
      r_pwm <= i_en && (i_pwm_cnt < r_duty);
    end
  end
  assign o_duty = r_duty;
  assign o_state = r_state;
  assign o_pwm = r_pwm;
  assign o_leave_off = i_tick && r_state == OFF && w_done;
endmodule

// File: rtl/rgb_fade_engine.sv
// rgb_fade_engine: shared step prescaler and PWM counter driving NUM_CH phase-staggered fade channels
module rgb_fade_engine import fade_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int STEP_INTERVAL = 12000,
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS = 200,
  parameter int HOLD_STEPS = 400,
  parameter int OFF_STEPS = 400,
  parameter int PHASE_STEPS = 400,
  localparam int DW = duty_w(PWM_INTERVAL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH*DW-1:0] duty,
  output logic [NUM_CH*3-1:0]  ch_state,
  output logic                 cycle_done
);
  localparam int SW = $clog2(STEP_INTERVAL + 1);
  logic [SW-1:0] r_step_cnt;
  logic [DW-1:0] r_pwm_cnt;
  logic r_cycle_done, w_tick;
  logic [NUM_CH-1:0] w_leave_off;
  assign w_tick = enable && r_step_cnt == SW'(STEP_INTERVAL - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt <= '0;
      r_pwm_cnt <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      if (enable) begin
        r_step_cnt <= w_tick ? '0 : r_step_cnt + 1'b1;
        r_pwm_cnt <= (r_pwm_cnt == DW'(PWM_INTERVAL - 1)) ? '0 : r_pwm_cnt + 1'b1;
      end
      // only channel 0 marks the start of a new fade cycle
      r_cycle_done <= |(w_leave_off & NUM_CH'(1));
    end
  end
  assign cycle_done = r_cycle_done;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fade_channel #(
      .STEPS(STEPS),
      .HOLD_STEPS(HOLD_STEPS),
      .OFF_STEPS(OFF_STEPS),
      .PWM_INTERVAL(PWM_INTERVAL),
      .START_DELAY(k * PHASE_STEPS)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .i_en(enable),
      .i_tick(w_tick),
      .i_pwm_cnt(r_pwm_cnt),
      .o_duty(duty[k*DW+:DW]),
      .o_state(ch_state[k*3+:3]),
      .o_pwm(pwm_out[k]),
      .o_leave_off(w_leave_off[k])
    );
  end
endmodule

// File: tb/tb_rgb_fade_engine.sv
// tb_rgb_fade_engine: randomized enable/reset run against a tick-count brightness model
module tb_rgb_fade_engine;
  localparam int N = 3, SI = 4, PI = 12, S = 4, H = 8, O = 8, PH = 8, DW = 4;
  localparam int DS = PI / S, PER = 2 * S + H + O;
  logic clk = 0, rst = 1, enable = 0;
  logic [N-1:0] pwm_out;
  logic [N*DW-1:0] duty;
  logic [N*3-1:0] ch_state;
  logic cycle_done;
  int errors = 0, checks = 0, n_cd = 0;
  int m_sc, m_pc, m_t;
  logic [N-1:0] m_pwm;
  logic m_cd;
  rgb_fade_engine #(.NUM_CH(N), .STEP_INTERVAL(SI), .PWM_INTERVAL(PI), .STEPS(S),
    .HOLD_STEPS(H), .OFF_STEPS(O), .PHASE_STEPS(PH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm_out(pwm_out), .duty(duty),
    .ch_state(ch_state), .cycle_done(cycle_done));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, m_t);
    end
  endtask
  // position of channel k inside its fade cycle after t ticks, -1 while still delayed
  function automatic int pos(input int k, input int t);
    return (t < k * PH) ? -1 : (t - k * PH) % PER;
  endfunction
  function automatic int exp_duty(input int k, input int t);
    int p = pos(k, t);
    if (p < 0) return 0;
    if (p <= S) return (p == S || p * DS > PI) ? PI : p * DS;
    if (p < S + H) return PI;
    if (p <= 2 * S + H) begin
      int q = p - S - H;
      return (q == S || q * DS > PI) ? 0 : PI - q * DS;
    end
    return 0;
  endfunction
  function automatic int exp_state(input int k, input int t);
    int p = pos(k, t);
    return p < 0 ? 0 : p < S ? 1 : p < S + H ? 2 : p < 2 * S + H ? 3 : 4;
  endfunction
  task automatic clk_step(input logic en, input logic rs);
    logic tk;
    logic [N*DW-1:0] dv;
    logic [N*3-1:0] sv;
    enable = en;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_sc = 0; m_pc = 0; m_t = 0; m_pwm = '0; m_cd = 0;
    end else if (en) begin
      for (int k = 0; k < N; k++) m_pwm[k] = m_pc < exp_duty(k, m_t);
      tk = m_sc == SI - 1;
      m_sc = tk ? 0 : m_sc + 1;
      m_pc = (m_pc == PI - 1) ? 0 : m_pc + 1;
      if (tk) m_t++;
      m_cd = tk && m_t % PER == 0;
    end else begin
      m_pwm = '0; m_cd = 0;
    end
    for (int k = 0; k < N; k++) begin
      dv[k*DW+:DW] = DW'(exp_duty(k, m_t));
      sv[k*3+:3] = 3'(exp_state(k, m_t));
    end
    #1;
    check("duty", duty, dv);
    check("ch_state", ch_state, sv);
    check("pwm_out", pwm_out, m_pwm);
    check("cycle_done", cycle_done, m_cd);
    n_cd += int'(cycle_done);
  endtask
  initial begin
    clk_step(0, 1);
    clk_step(0, 1);
    repeat (57) clk_step(1, 0);
    check("dec_duty6", duty[DW-1:0], 6);
    repeat (20) clk_step(0, 0);
    check("frozen_duty", duty[DW-1:0], 6);
    check("frozen_pwm", pwm_out, 0);
    repeat (4) clk_step(1, 0);
    check("resume_duty", duty[DW-1:0], 3);
    repeat (100) clk_step(1, 0);
    check("cd_count", n_cd, 1);
    repeat (3) clk_step(1, 1);
    check("rst_state", ch_state, 9'b000_000_001);
    check("rst_duty", duty, 0);
    check("rst_pwm", pwm_out, 0);
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) repeat (3) clk_step(1, 1);
      else clk_step($urandom_range(0, 7) != 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
